cpu_alu_arb: RTL and testbench

CPU_ALU_ARB -- requirements
Module: cpu_alu_arb

---
 rtl/cpu_alu_arb_if.sv | 45 ++++
 rtl/cpu_alu_arb.sv | 109 ++++++++++
 tb/tb_cpu_alu_arb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_alu_arb_if.sv
// Bundle of two requester command ports, the shared-ALU port and the response port.
// Latency: none, wires only.
// Backpressure: valid/ready on both requester ports and on the response port.
interface cpu_alu_arb_if;
   logic       req0_valid_i;
   logic       req0_ready_o;
   logic [7:0] req0_a_i;
   logic [7:0] req0_b_i;
   logic [3:0] req0_op_i;
   logic       req1_valid_i;
   logic       req1_ready_o;
   logic [7:0] req1_a_i;
   logic [7:0] req1_b_i;
   logic [3:0] req1_op_i;
   logic [7:0] alu_a_o;
   logic [7:0] alu_b_o;
   logic [3:0] alu_op_o;
   logic [7:0] alu_y_i;
   logic [3:0] alu_flags_i;
   logic       rsp_valid_o;
   logic       rsp_ready_i;
   logic       rsp_id_o;
   logic [7:0] rsp_y_o;
   logic [3:0] rsp_flags_o;

   // Arbiter side.
   modport slave (
      input  req0_valid_i, req0_a_i, req0_b_i, req0_op_i,
      input  req1_valid_i, req1_a_i, req1_b_i, req1_op_i,
      input  alu_y_i, alu_flags_i, rsp_ready_i,
      output req0_ready_o, req1_ready_o,
      output alu_a_o, alu_b_o, alu_op_o,
      output rsp_valid_o, rsp_id_o, rsp_y_o, rsp_flags_o
   );

   // Requesters, ALU and response consumer side.
   modport master (
      output req0_valid_i, req0_a_i, req0_b_i, req0_op_i,
      output req1_valid_i, req1_a_i, req1_b_i, req1_op_i,
      output alu_y_i, alu_flags_i, rsp_ready_i,
      input  req0_ready_o, req1_ready_o,
      input  alu_a_o, alu_b_o, alu_op_o,
      input  rsp_valid_o, rsp_id_o, rsp_y_o, rsp_flags_o
   );
endinterface

// File: rtl/cpu_alu_arb.sv
// Two-requester arbiter in front of one shared combinational ALU, one command in flight.
// Latency: accept in cycle N, ALU driven in N+1, response valid from N+2.
// Backpressure: response held until rsp_ready_i; requesters see ready only in IDLE.
// Option: define CPU_ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties);
// otherwise ties are resolved round-robin via a last-grant register.
module cpu_alu_arb (
   input  logic          clk_i,
   input  logic          rst_i,
   cpu_alu_arb_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state;
   logic       grant0;
   logic       grant1;
   logic       hs0;
   logic       hs1;
   logic       id_r;
   logic [7:0] alu_a_r;
   logic [7:0] alu_b_r;
   logic [3:0] alu_op_r;
   logic       rsp_valid_r;
   logic       rsp_id_r;
   logic [7:0] rsp_y_r;
   logic [3:0] rsp_flags_r;

`ifdef CPU_ALU_ARB_FIXED_PRIO_EN
   // Fixed priority: requester 0 always wins a tie.
   always_comb begin
      grant0 = bus.req0_valid_i;
      grant1 = bus.req1_valid_i & ~bus.req0_valid_i;
   end
`else
   logic last_grant;

   // Round-robin: on a tie, grant the requester that did not win last time.
   always_comb begin
      grant1 = bus.req1_valid_i & (~bus.req0_valid_i | ~last_grant);
      grant0 = bus.req0_valid_i & ~grant1;
   end

   // Remember the winner of the most recent accepted command; reset favours requester 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         last_grant <= 1'b1;
      else if (hs0 | hs1)
         last_grant <= hs1;
   end
`endif

   assign bus.req0_ready_o = (state == IDLE) & grant0;
   assign bus.req1_ready_o = (state == IDLE) & grant1;
   assign hs0 = bus.req0_valid_i & bus.req0_ready_o;
   assign hs1 = bus.req1_valid_i & bus.req1_ready_o;

   assign bus.alu_a_o     = alu_a_r;
   assign bus.alu_b_o     = alu_b_r;
   assign bus.alu_op_o    = alu_op_r;
   assign bus.rsp_valid_o = rsp_valid_r;
   assign bus.rsp_id_o    = rsp_id_r;
   assign bus.rsp_y_o     = rsp_y_r;
   assign bus.rsp_flags_o = rsp_flags_r;

   // Command FSM: operand registers double as the ALU drive and are non-zero only in EXEC.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         id_r        <= 1'b0;
         alu_a_r     <= 8'h00;
         alu_b_r     <= 8'h00;
         alu_op_r    <= 4'h0;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= 1'b0;
         rsp_y_r     <= 8'h00;
         rsp_flags_r <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               if (hs0 | hs1) begin
                  alu_a_r  <= hs1 ? bus.req1_a_i  : bus.req0_a_i;
                  alu_b_r  <= hs1 ? bus.req1_b_i  : bus.req0_b_i;
                  alu_op_r <= hs1 ? bus.req1_op_i : bus.req0_op_i;
                  id_r     <= hs1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               rsp_y_r     <= bus.alu_y_i;
               rsp_flags_r <= bus.alu_flags_i;
               rsp_id_r    <= id_r;
               rsp_valid_r <= 1'b1;
               alu_a_r     <= 8'h00;
               alu_b_r     <= 8'h00;
               alu_op_r    <= 4'h0;
               state       <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid_r <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_alu_arb.sv
// Bench for cpu_alu_arb: a small ALU drives the shared-ALU port, a transaction-level
// model predicts every output each cycle, and directed scenarios pin literal results.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cpu_alu_arb;

   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h5;
`ifdef CPU_ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cpu_alu_arb_if bus ();
   cpu_alu_arb dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] rsp_ids[$];

   // Reference ALU: returns {z,c,v,n, y}.
   function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      logic [8:0] w;
      logic [7:0] y;
      logic c, v;
      w = 9'h000; c = 1'b0; v = 1'b0;
      case (op)
         OP_ADD: begin
            w = {1'b0, a} + {1'b0, b};
            c = w[8];
            v = (a[7] == b[7]) && (w[7] != a[7]);
         end
         OP_SUB: begin
            w = {1'b0, a} - {1'b0, b};
            c = w[8];
            v = (a[7] != b[7]) && (w[7] != a[7]);
         end
         OP_AND:  w = {1'b0, a & b};
         OP_XOR:  w = {1'b0, a ^ b};
         default: w = {1'b0, a | b};
      endcase
      y = w[7:0];
      return {(y == 8'h00), c, v, y[7], y};
   endfunction

   assign {bus.alu_flags_i, bus.alu_y_i} = alu_ref(bus.alu_a_o, bus.alu_b_o, bus.alu_op_o);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level model: one command in flight, aged in cycles since acceptance.
   bit         m_busy = 1'b0;
   int         m_age  = 0;
   int         m_last = 1;
   int         m_id   = 0;
   logic [7:0] m_a, m_b, m_y;
   logic [3:0] m_op, m_f;
   int         m_rid  = 0;

   always @(negedge clk) begin
      logic v0, v1, e_r0, e_r1, e_exec, e_rsp;
      int win;
      if (rst) begin
         m_busy = 1'b0; m_last = 1; m_y = 8'h00; m_f = 4'h0; m_rid = 0;
      end
      v0 = bus.req0_valid_i;
      v1 = bus.req1_valid_i;
      if (v0 && v1) win = FIXED ? 0 : 1 - m_last;
      else          win = v1 ? 1 : 0;
      e_r0   = !rst && !m_busy && v0 && (win == 0);
      e_r1   = !rst && !m_busy && v1 && (win == 1);
      e_exec = !rst && m_busy && (m_age == 1);
      e_rsp  = !rst && m_busy && (m_age >= 2);
      chk("req0_ready", bus.req0_ready_o, e_r0);
      chk("req1_ready", bus.req1_ready_o, e_r1);
      chk("alu_a",  bus.alu_a_o,  e_exec ? m_a  : 8'h00);
      chk("alu_b",  bus.alu_b_o,  e_exec ? m_b  : 8'h00);
      chk("alu_op", bus.alu_op_o, e_exec ? m_op : 4'h0);
      chk("rsp_valid", bus.rsp_valid_o, e_rsp);
      chk("rsp_y",     bus.rsp_y_o,     m_y);
      chk("rsp_flags", bus.rsp_flags_o, m_f);
      chk("rsp_id",    bus.rsp_id_o,    m_rid);
      if (bus.rsp_valid_o && bus.rsp_ready_i)
         rsp_ids.push_back(32'(bus.rsp_id_o));
      if (!rst) begin
         if (!m_busy) begin
            if (e_r0 || e_r1) begin
               m_a    = (win == 1) ? bus.req1_a_i  : bus.req0_a_i;
               m_b    = (win == 1) ? bus.req1_b_i  : bus.req0_b_i;
               m_op   = (win == 1) ? bus.req1_op_i : bus.req0_op_i;
               m_id   = win;
               m_last = win;
               m_busy = 1'b1;
               m_age  = 1;
            end
         end else if (m_age == 1) begin
            {m_f, m_y} = alu_ref(m_a, m_b, m_op);
            m_rid = m_id;
            m_age = 2;
         end else if (bus.rsp_ready_i) begin
            m_busy = 1'b0;
         end
      end
   end

   // Present a command and return 1 time unit after the edge that accepted it.
   task automatic send(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      bit got;
      got = 1'b0;
      if (id == 0) begin
         bus.req0_a_i = a; bus.req0_b_i = b; bus.req0_op_i = op; bus.req0_valid_i = 1'b1;
      end else begin
         bus.req1_a_i = a; bus.req1_b_i = b; bus.req1_op_i = op; bus.req1_valid_i = 1'b1;
      end
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if ((id == 0) ? bus.req0_ready_o : bus.req1_ready_o) got = 1'b1;
      end
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (id == 0) bus.req0_valid_i = 1'b0;
      else         bus.req1_valid_i = 1'b0;
   endtask

   initial begin
      int pulses;
      int exp_g[4];
      rst = 1'b1;
      bus.req0_valid_i = 1'b0; bus.req0_a_i = 8'h00; bus.req0_b_i = 8'h00; bus.req0_op_i = 4'h0;
      bus.req1_valid_i = 1'b0; bus.req1_a_i = 8'h00; bus.req1_b_i = 8'h00; bus.req1_op_i = 4'h0;
      bus.rsp_ready_i  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rsp_valid", bus.rsp_valid_o, 1'b0);
      chk("reset_rsp_y",     bus.rsp_y_o,     8'h00);
      @(posedge clk); #1 rst = 1'b0;

      // 05 + 03 from requester 0: response exactly two cycles after acceptance.
      bus.rsp_ready_i = 1'b1;
      send(0, 8'h05, 8'h03, OP_ADD);
      @(negedge clk);
      chk("add_n1_rsp_valid", bus.rsp_valid_o, 1'b0);
      chk("add_n1_alu_a",     bus.alu_a_o,     8'h05);
      @(negedge clk);
      chk("add_n2_rsp_valid", bus.rsp_valid_o, 1'b1);
      chk("add_y",            bus.rsp_y_o,     8'h08);
      chk("add_flags",        bus.rsp_flags_o, 4'b0000);
      chk("add_id",           bus.rsp_id_o,    1'b0);
      @(posedge clk); #1;

      // 7F + 01 from requester 1 with the consumer stalled; requester 0 waits meanwhile.
      bus.rsp_ready_i = 1'b0;
      send(1, 8'h7F, 8'h01, OP_ADD);
      bus.req0_a_i = 8'h11; bus.req0_b_i = 8'h22; bus.req0_op_i = OP_XOR; bus.req0_valid_i = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", bus.rsp_valid_o,  1'b1);
         chk("hold_y",         bus.rsp_y_o,      8'h80);
         chk("hold_flags",     bus.rsp_flags_o,  4'b0011);
         chk("hold_id",        bus.rsp_id_o,     1'b1);
         chk("hold_no_ready0", bus.req0_ready_o, 1'b0);
      end
      @(posedge clk); #1;
      bus.req0_valid_i = 1'b0;
      bus.rsp_ready_i  = 1'b1;
      @(posedge clk); #1;

      // 00 - 01 from requester 0.
      send(0, 8'h00, 8'h01, OP_SUB);
      @(negedge clk);
      @(negedge clk);
      chk("sub_y",     bus.rsp_y_o,     8'hFF);
      chk("sub_flags", bus.rsp_flags_o, 4'b0101);
      chk("sub_id",    bus.rsp_id_o,    1'b0);
      @(posedge clk); #1;

      // Reset while the command is executing: it must vanish without a response.
      send(0, 8'h3C, 8'h0F, OP_AND);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_exec_alu_a",     bus.alu_a_o,     8'h00);
      chk("rst_exec_alu_op",    bus.alu_op_o,    4'h0);
      chk("rst_exec_rsp_valid", bus.rsp_valid_o, 1'b0);
      chk("rst_exec_rsp_y",     bus.rsp_y_o,     8'h00);
      @(posedge clk); #1 rst = 1'b0;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.rsp_valid_o) pulses++;
      end
      chk("rst_exec_no_rsp", pulses, 0);

      // Both requesters valid continuously: grant order of the first four responses.
      @(posedge clk); #1;
      rsp_ids.delete();
      bus.req0_a_i = 8'h10; bus.req0_b_i = 8'h20; bus.req0_op_i = OP_AND;
      bus.req1_a_i = 8'hF0; bus.req1_b_i = 8'h0F; bus.req1_op_i = OP_XOR;
      bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1;
      bus.rsp_ready_i  = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
      if (FIXED) begin
         exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
      end else begin
         exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
      end
      chk("tie_rsp_count_ge4", 32'(rsp_ids.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++)
         chk("tie_grant_order", (i < rsp_ids.size()) ? rsp_ids[i] : 32'hFFFF_FFFF, exp_g[i]);

      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
